// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract unit with the ripple carry split into STAGES registered segments behind a valid/ready handshake
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG = WIDTH / STAGES;
  localparam int L   = STAGES - 1;
  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [STAGES-1:0] v_q, v_d, c_q, c_d, ci;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [SEG:0]      seg_sum;

  assign b_eff     = sub ? ~b : b;
  assign c0        = sub ? ~cin : cin;
  assign adv       = !v_q[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[L];
  assign s         = s_q[L];
  assign cout      = c_q[L];
  assign ovf       = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

  // each stage takes its predecessor's operands, partial sum and carry, then resolves its own segment
  always_comb begin
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = in_valid;
      a_d[k] = a;
      b_d[k] = b_eff;
      s_d[k] = '0;
      ci[k]  = c0;
      c_d[k] = 1'b0;
    end
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
      ci[k]  = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_sum = {1'b0, a_d[k][k*SEG +: SEG]} + {1'b0, b_d[k][k*SEG +: SEG]} + (SEG+1)'(ci[k]);
      s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[k] = seg_sum[SEG];
    end
  end

  // whole pipe advances together or freezes together; reset clears valids and data
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end
endmodule
